rob_commit: RTL and testbench

In-order reorder buffer for the out-of-order core. It allocates ROB tags to issuing instructions and captures results from the common data bus (CDB). It retires entries strictly in program order and drives the register file's commit-side unlock interface (`unlock`, `unlock_rd`, `unlock_robpos`, `unlock_val`). It is the commit-side counterpart of the register file's rename lock, and also serves operand lookups by ROB tag for issue.

---
 rtl/rob_commit.sv | 150 +++++++++++++++
 tb/tb_rob_commit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates tags at issue, captures CDB results, retires in order
// and drives the register-file unlock port. Define ROB_WB_BYPASS_EN to forward the CDB beat.
module rob_commit #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_has_rd,
    input  logic [REG_W-1:0]  issue_rd,
    output logic [ROB_W-1:0]  alloc_robpos,
    output logic              full,
    output logic              empty,
    input  logic              wb_valid,
    input  logic [ROB_W-1:0]  wb_robpos,
    input  logic [DATA_W-1:0] wb_val,
    input  logic [ROB_W-1:0]  q1_robpos,
    input  logic [ROB_W-1:0]  q2_robpos,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_val,
    output logic [DATA_W-1:0] q2_val,
    output logic              commit_valid,
    output logic              unlock,
    output logic [REG_W-1:0]  unlock_rd,
    output logic [ROB_W-1:0]  unlock_robpos,
    output logic [DATA_W-1:0] unlock_val
);
    localparam int unsigned CNT_W = ROB_W + 1;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  has_rd;
    logic [REG_W-1:0]  rd_q  [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [ROB_W-1:0]  head;
    logic [ROB_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              do_alloc;
    logic              wb_hit;
    logic              head_done;
    logic [DATA_W-1:0] head_val;
    logic              do_commit;
    logic              q1_reg_ready;
    logic              q2_reg_ready;
    logic              q1_wb;
    logic              q2_wb;

    assign alloc_robpos = tail;
    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);

    assign do_alloc     = issue_valid && !full;
    assign wb_hit       = wb_valid && busy[wb_robpos];
    assign q1_reg_ready = busy[q1_robpos] && done[q1_robpos];
    assign q2_reg_ready = busy[q2_robpos] && done[q2_robpos];

`ifdef ROB_WB_BYPASS_EN
    // Same-cycle CDB beat counts as a result for both lookup and head retirement.
    assign q1_wb     = wb_hit && (wb_robpos == q1_robpos);
    assign q2_wb     = wb_hit && (wb_robpos == q2_robpos);
    assign head_done = done[head] || (wb_hit && (wb_robpos == head));
    assign head_val  = (wb_hit && (wb_robpos == head)) ? wb_val : val_q[head];
`else
    assign q1_wb     = 1'b0;
    assign q2_wb     = 1'b0;
    assign head_done = done[head];
    assign head_val  = val_q[head];
`endif

    assign do_commit = busy[head] && head_done;

    assign q1_ready = q1_reg_ready || q1_wb;
    assign q2_ready = q2_reg_ready || q2_wb;
    assign q1_val   = q1_wb ? wb_val : (q1_reg_ready ? val_q[q1_robpos] : '0);
    assign q2_val   = q2_wb ? wb_val : (q2_reg_ready ? val_q[q2_robpos] : '0);

    // Entry state, pointers and registered commit port; freeze beats flush beats normal work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= '0;
            done          <= '0;
            has_rd        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            unlock        <= 1'b0;
            unlock_rd     <= '0;
            unlock_robpos <= '0;
            unlock_val    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
        end else if (!ready) begin
            commit_valid  <= 1'b0;
            unlock        <= 1'b0;
            unlock_rd     <= '0;
            unlock_robpos <= '0;
            unlock_val    <= '0;
        end else if (flush) begin
            busy          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            unlock        <= 1'b0;
            unlock_rd     <= '0;
            unlock_robpos <= '0;
            unlock_val    <= '0;
        end else begin
            if (wb_hit) begin
                done[wb_robpos]  <= 1'b1;
                val_q[wb_robpos] <= wb_val;
            end
            if (do_commit) begin
                busy[head]    <= 1'b0;
                head          <= head + ROB_W'(1);
                commit_valid  <= 1'b1;
                unlock        <= has_rd[head];
                unlock_rd     <= rd_q[head];
                unlock_robpos <= head;
                unlock_val    <= head_val;
            end else begin
                commit_valid  <= 1'b0;
                unlock        <= 1'b0;
                unlock_rd     <= '0;
                unlock_robpos <= '0;
                unlock_val    <= '0;
            end
            // A non-busy tail cannot be hit by writeback, so done[tail] has a single writer here.
            if (do_alloc) begin
                busy[tail]   <= 1'b1;
                done[tail]   <= 1'b0;
                has_rd[tail] <= issue_has_rd && (issue_rd != '0);
                rd_q[tail]   <= issue_rd;
                tail         <= tail + ROB_W'(1);
            end
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: scoreboard of expected retirements checked by a commit monitor.
module tb_rob_commit;
    logic        clk;
    logic        reset;
    logic        ready;
    logic        flush;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic [4:0]  alloc_robpos;
    logic        full;
    logic        empty;
    logic        wb_valid;
    logic [4:0]  wb_robpos;
    logic [31:0] wb_val;
    logic [4:0]  q1_robpos;
    logic [4:0]  q2_robpos;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_val;
    logic [31:0] q2_val;
    logic        commit_valid;
    logic        unlock;
    logic [4:0]  unlock_rd;
    logic [4:0]  unlock_robpos;
    logic [31:0] unlock_val;

    typedef struct {
        logic        unl;
        logic [4:0]  rd;
        logic [4:0]  pos;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int          n_commits = 0;
    int          n0;
    logic [4:0]  m_tail;

`ifdef ROB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    rob_commit dut (
        .clk(clk), .reset(reset), .ready(ready), .flush(flush),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .alloc_robpos(alloc_robpos), .full(full), .empty(empty),
        .wb_valid(wb_valid), .wb_robpos(wb_robpos), .wb_val(wb_val),
        .q1_robpos(q1_robpos), .q2_robpos(q2_robpos),
        .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val),
        .commit_valid(commit_valid), .unlock(unlock), .unlock_rd(unlock_rd),
        .unlock_robpos(unlock_robpos), .unlock_val(unlock_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic alloc(input logic has, input logic [4:0] r, input logic [31:0] v, input bit track);
        exp_t e;
        chk("alloc_robpos", 32'(alloc_robpos), 32'(m_tail));
        if (track) begin
            e.unl = has && (r != 5'd0);
            e.rd  = r;
            e.pos = m_tail;
            e.val = v;
            sb.push_back(e);
        end
        issue_valid  = 1'b1;
        issue_has_rd = has;
        issue_rd     = r;
        tick();
        issue_valid  = 1'b0;
        m_tail       = m_tail + 5'd1;
    endtask

    task automatic wb(input logic [4:0] t, input logic [31:0] v);
        wb_valid  = 1'b1;
        wb_robpos = t;
        wb_val    = v;
        tick();
        wb_valid  = 1'b0;
    endtask

    // Commit monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (commit_valid) begin
                exp_t e;
                n_commits++;
                chk("commit_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("unlock", 32'(unlock), 32'(e.unl));
                    chk("unlock_robpos", 32'(unlock_robpos), 32'(e.pos));
                    chk("unlock_val", unlock_val, e.val);
                    if (e.unl) chk("unlock_rd", 32'(unlock_rd), 32'(e.rd));
                end
            end else begin
                chk("idle_unlock", 32'(unlock), 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b0; ready = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_robpos = '0; wb_val = '0;
        q1_robpos = '0; q2_robpos = '0;
        m_tail = '0;
        #2;
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_unlock", 32'(unlock), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_alloc_robpos", 32'(alloc_robpos), 32'd0);
        #10 reset = 1'b1;
        tick();

        // In-order retire despite out-of-order writeback
        alloc(1'b1, 5'd3, 32'hA, 1'b1);
        alloc(1'b1, 5'd4, 32'hB, 1'b1);
        alloc(1'b1, 5'd5, 32'hC, 1'b1);
        chk("empty_live", 32'(empty), 32'd0);
        wb(5'd2, 32'hC);
        wb(5'd0, 32'hA);
        wb(5'd1, 32'hB);
        idle(4);
        chk("inorder_commits", 32'(n_commits), 32'd3);
        chk("inorder_empty", 32'(empty), 32'd1);

        // rd=0 and no-rd entries retire without unlock
        alloc(1'b1, 5'd0, 32'h11, 1'b1);
        alloc(1'b0, 5'd7, 32'h22, 1'b1);
        wb(5'd3, 32'h11);
        wb(5'd4, 32'h22);
        idle(3);
        chk("nord_commits", 32'(n_commits), 32'd5);

        // Flush with live entries and a same-cycle writeback to the head
        for (int i = 0; i < 4; i++) alloc(1'b1, 5'(i + 1), 32'h0, 1'b0);
        flush = 1'b1; wb_valid = 1'b1; wb_robpos = 5'd5; wb_val = 32'hDEAD;
        tick();
        flush = 1'b0; wb_valid = 1'b0;
        m_tail = '0;
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_tag", 32'(alloc_robpos), 32'd0);
        idle(3);
        chk("flush_no_commit", 32'(n_commits), 32'd5);

        // ready low freezes a done head
        alloc(1'b1, 5'd9, 32'h77, 1'b1);
        alloc(1'b1, 5'd10, 32'h88, 1'b1);
        wb(5'd1, 32'h88);
        n0 = n_commits;
        wb(5'd0, 32'h77);
        ready = 1'b0;
        idle(3);
        chk("ready_frozen", 32'(n_commits), 32'(n0 + (BYP ? 1 : 0)));
        ready = 1'b1;
        idle(3);
        chk("ready_resume", 32'(n_commits), 32'(n0 + 2));

        // CDB lookup: same-cycle forward only with bypass
        for (int i = 2; i < 8; i++)
            alloc(1'b1, 5'(i + 10), (i == 7) ? 32'h55 : 32'(256 + i), 1'b1);
        q1_robpos = 5'd7; q2_robpos = 5'd3;
        wb_valid = 1'b1; wb_robpos = 5'd7; wb_val = 32'h55;
        #1;
        chk("q1_ready_same", 32'(q1_ready), 32'(BYP));
        chk("q1_val_same", q1_val, BYP ? 32'h55 : 32'h0);
        chk("q2_ready_pending", 32'(q2_ready), 32'd0);
        chk("q2_val_pending", q2_val, 32'h0);
        tick();
        wb_valid = 1'b0;
        q2_robpos = 5'd7;
        #1;
        chk("q1_ready_next", 32'(q1_ready), 32'd1);
        chk("q1_val_next", q1_val, 32'h55);
        chk("q2_ready_next", 32'(q2_ready), 32'd1);
        for (int i = 2; i < 7; i++) wb(5'(i), 32'(256 + i));
        idle(4);
        chk("bypass_commits", 32'(n_commits), 32'd13);
        chk("bypass_empty", 32'(empty), 32'd1);

        // Fill to full, refuse a 33rd issue, free slot 0 and wrap
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_tail = '0;
        for (int i = 0; i < 32; i++) alloc(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b1);
        chk("full_set", 32'(full), 32'd1);
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("full_refuse", 32'(full), 32'd1);
        chk("full_tail", 32'(alloc_robpos), 32'd0);
        wb(5'd0, 32'h1000);
        idle(2);
        chk("full_freed", 32'(full), 32'd0);
        alloc(1'b1, 5'd1, 32'hBEEF, 1'b1);
        chk("full_again", 32'(full), 32'd1);
        for (int i = 1; i < 32; i++) wb(5'(i), 32'h1000 + 32'(i));
        wb(5'd0, 32'hBEEF);
        idle(4);
        chk("wrap_commits", 32'(n_commits), 32'd46);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset between edges with live entries
        for (int i = 0; i < 5; i++) alloc(1'b1, 5'(i + 1), 32'h0, 1'b0);
        chk("pre_reset_empty", 32'(empty), 32'd0);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_tag", 32'(alloc_robpos), 32'd0);
        chk("mid_rst_commit", 32'(commit_valid), 32'd0);
        chk("mid_rst_unlock", 32'(unlock), 32'd0);
        chk("mid_rst_val", unlock_val, 32'd0);
        #2 reset = 1'b1;
        m_tail = '0;
        idle(2);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_tag", 32'(alloc_robpos), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
